// File: rtl/bounded_updown_counter.sv
// Up/down counter with programmable step and inclusive bounds.
// Out-of-range steps either wrap, saturate, or saturate and reverse (bounce).
module bounded_updown_counter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              up,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [STEP_W-1:0] step,
   input  logic [WIDTH-1:0]  min_val,
   input  logic [WIDTH-1:0]  max_val,
   input  logic [1:0]        mode,
   input  logic              clr_flags,
   output logic [WIDTH-1:0]  count,
   output logic              dir,
   output logic              at_max,
   output logic              at_min,
   output logic              tc,
   output logic              ovf_sticky,
   output logic              unf_sticky
);

   localparam logic [1:0] MODE_WRAP   = 2'b00;
   localparam logic [1:0] MODE_SAT    = 2'b01;
   localparam logic [1:0] MODE_BOUNCE = 2'b10;

   logic [WIDTH-1:0] r_count;
   logic             r_dir;
   logic             r_tc;
   logic             r_ovf;
   logic             r_unf;

   logic             w_bounce;
   logic             w_wrap;
   logic             w_eff_up;
   logic             w_bad_cfg;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_dn_lim;
   logic             w_ovf_evt;
   logic             w_unf_evt;
   logic [WIDTH-1:0] w_next;
   logic             w_next_dir;

   assign w_bounce  = (mode == MODE_BOUNCE);
   assign w_wrap    = (mode != MODE_SAT) && !w_bounce;
   assign w_eff_up  = w_bounce ? r_dir : up;
   assign w_bad_cfg = (min_val > max_val);

   // One extra bit so neither count+step nor min+step can truncate.
   assign w_sum    = (WIDTH+1)'(r_count) + (WIDTH+1)'(step);
   assign w_dn_lim = (WIDTH+1)'(min_val) + (WIDTH+1)'(step);

   always_comb begin
      w_ovf_evt  = 1'b0;
      w_unf_evt  = 1'b0;
      w_next     = r_count;
      w_next_dir = w_bounce ? r_dir : up;
      if (load) begin
         w_next     = load_val;
         w_next_dir = up;
      end else if (enable && !w_bad_cfg) begin
         if (w_eff_up) begin
            if (w_sum > (WIDTH+1)'(max_val)) begin
               w_ovf_evt = 1'b1;
               w_next    = w_wrap ? min_val : max_val;
            end else begin
               w_next = w_sum[WIDTH-1:0];
            end
         end else begin
            if ((WIDTH+1)'(r_count) < w_dn_lim) begin
               w_unf_evt = 1'b1;
               w_next    = w_wrap ? max_val : min_val;
            end else begin
               w_next = r_count - WIDTH'(step);
            end
         end
         if (w_bounce && (w_ovf_evt || w_unf_evt))
            w_next_dir = ~r_dir;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_dir   <= 1'b1;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_next;
         r_dir   <= w_next_dir;
         r_tc    <= w_ovf_evt || w_unf_evt;
         // A new event outranks a coincident clear.
         r_ovf   <= w_ovf_evt || (r_ovf && !clr_flags);
         r_unf   <= w_unf_evt || (r_unf && !clr_flags);
      end
   end

   assign count      = r_count;
   assign dir        = w_eff_up;
   assign at_max     = (r_count == max_val);
   assign at_min     = (r_count == min_val);
   assign tc         = r_tc;
   assign ovf_sticky = r_ovf;
   assign unf_sticky = r_unf;

endmodule

// File: doc/bounded_updown_counter.md
# bounded_updown_counter

Parametrised up/down counter with programmable step, programmable lower and upper bounds, and three boundary modes: wrap, saturate and bounce. It also provides terminal-count pulses and sticky overflow/underflow flags. It is the general-purpose successor to the fixed-width free-running up/down counter. It serves as a timer, address or ramp generator wherever software-configurable limits are needed.

## Interface
- WIDTH, 8, count and bound width
- STEP_W, 4, step width; must be ≤ WIDTH
- clk  input  1  clock, rising edge
- rst_n  input  1  reset; one clock, asynchronous, active-low
- enable  input  1  advance count by step this cycle
- up  input  1  direction: 1 = up, 0 = down (ignored in bounce mode except on load)
- load  input  1  synchronous load; overrides enable
- load_val  input  WIDTH  value loaded on load
- step  input  STEP_W  increment magnitude, zero-extended
- min_val  input  WIDTH  lower bound, inclusive
- max_val  input  WIDTH  upper bound, inclusive
- mode  input  2  00 wrap, 01 saturate, 10 bounce, 11 treated as wrap
- clr_flags  input  1  clear ovf_sticky/unf_sticky
- count  output  WIDTH  current count, registered
- dir  output  1  effective direction: dir_q in bounce mode, else up
- at_max  output  1  combinational, count == max_val
- at_min  output  1  combinational, count == min_val
- tc  output  1  registered one-cycle boundary-event pulse
- ovf_sticky  output  1  registered; set on any up-boundary event
- unf_sticky  output  1  registered; set on any down-boundary event

## Operation
- Priority per cycle: rst_n low, then load, then enable, then hold.
- Arithmetic is unsigned, WIDTH+1 bits, with step zero-extended. No intermediate result truncates.
- Up overflow event: count + step > max_val.
- Down underflow event: count < min_val + step, including count < step.
- Counting without an event: count ± step.
- Overflow in wrap mode: count ← min_val.
- Underflow in wrap mode: count ← max_val.
- Overflow/underflow in saturate mode: count ← max_val / min_val.
- Overflow/underflow in bounce mode: count clamps as in saturate, and dir_q inverts.
- Bounce mode uses dir_q as the direction; up is ignored.
- dir_q rules:
  - Resets to 1.
  - dir_q ← up on load in any mode.
  - dir_q ← up every cycle while mode ≠ bounce, so entering bounce starts in the current up direction.
- Any event sets tc for exactly the next cycle. tc is coincident with the post-event count.
- Any event also sets the matching sticky flag.
- Sticky flags hold until clr_flags. When an event and clr_flags occur in the same cycle, set wins.
- step = 0: count holds; an event fires only if count is already outside the bounds.
- load_val is not clamped. An out-of-range count is pulled back by the next enabled step, which is an event.
- min_val > max_val (misconfiguration):
  - Enabled steps hold count.
  - No events fire and tc stays 0.
  - load still works.
- Bounds, step and mode are sampled every cycle; changes take effect immediately.

## Timing
- Reset values: count = 0, dir_q = 1, tc = 0, ovf_sticky = 0, unf_sticky = 0.
- at_max/at_min follow count and bounds combinationally.
- Latency: load or enable sampled at edge N is visible on count after edge N. tc is high for the cycle following edge N.
- Asserting rst_n low mid-count clears all registers immediately, without waiting for clk. Counting resumes from 0 on the first edge after deassertion.
- A continuously enabled counter in wrap mode with step 1 has period max_val − min_val + 1.
- tc is not asserted on load.

## Test plan
- Wrap: WIDTH=8, min=3, max=10, step=4, up, load 3, enable 4 cycles -> count 7, 3, 7, 3. tc is high after edges 2 and 4; ovf_sticky = 1.
- Saturate down: min=5, max=200, step=7, load 10, down, enable 3 cycles -> count 5, 5, 5. tc pulses after each edge; unf_sticky = 1; at_min = 1.
- Bounce: min=0, max=6, step=2, load 2 with up=1, enable 8 cycles -> count 4, 6, 6, 4, 2, 0, 0, 2. dir flips after edges 3 and 7.
- Priority and flags: load=1 with enable=1 at count=max -> count = load_val, tc = 0. Then clr_flags coincident with an overflow event -> ovf_sticky stays 1; clr_flags alone next cycle -> 0.
- Reset mid-operation: rst_n low between edges during bounce down -> outputs return to reset values at once, dir = 1. The first enabled cycle after release counts up from 0.
- Misconfiguration and step 0: min=9, max=4, enable 5 cycles -> count unchanged, tc = 0. With valid bounds, step=0 -> count holds, no tc.
